// File: rtl/atomic_alu_sequencer_if.sv
// atomic_alu_sequencer_if: command handshake, ALU drive/return and response
// signals of the atomic ALU sequencer. The master side is the environment
// (command source plus the external combinational ALU); the slave side is
// the sequencer.
interface atomic_alu_sequencer_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int OPC_W    = 3
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [OPC_W+3*ADDR_W-1:0] cmd_data;
    logic [OPC_W-1:0]          alu_op;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [DATA_W-1:0]         alu_y;
    logic                      alu_z;
    logic                      rsp_valid;
    logic                      rsp_status;

    modport master (
        output cmd_valid, cmd_data, alu_y, alu_z,
        input  cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_data, alu_y, alu_z,
        output cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_status
    );
endinterface

// File: rtl/atomic_alu_sequencer.sv
// atomic_alu_sequencer: handshaked register-file front end for an external
// combinational ALU. Commands {opcode,a1,a2,a3} read R[a1]/R[a2] into the
// ALU and write the result to R[a3]; opcode all-ones is an atomic
// compare-and-swap (R[a1]==R[a2] -> swap R[a1]/R[a3]) run as a SUB.
// R[NUM_REGS-1] is the STATUS register.
// Optional feature macro: CAS_STATS_EN adds saturating 16-bit CAS hit/miss
// counters on ports cas_ok_cnt / cas_fail_cnt.
module atomic_alu_sequencer #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 8,
    parameter  int OPC_W    = 3,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic clk,
    input  logic rst_n,
    atomic_alu_sequencer_if.slave bus
`ifdef CAS_STATS_EN
    ,
    output logic [15:0] cas_ok_cnt,
    output logic [15:0] cas_fail_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, EXEC, SWAP} state_t;

    localparam logic [OPC_W-1:0]  OP_CAS     = '1;
    localparam logic [OPC_W-1:0]  OP_SUB     = OPC_W'(1);
    localparam logic [ADDR_W-1:0] STATUS_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [OPC_W-1:0]    op_q;
    logic [ADDR_W-1:0]   a1_q, a2_q, a3_q;
    logic                z_q;
    logic                is_cas;
    logic                accept;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    assign bus.cmd_ready = (state_q == IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign is_cas        = (op_q == OP_CAS);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: IDLE -> ISSUE -> EXEC -> (CAS: SWAP) -> IDLE.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_d unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = EXEC;
            EXEC:    state_d = is_cas ? SWAP : IDLE;
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, ALU operand/opcode drive, CAS zero capture and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q           <= '0;
            a1_q           <= '0;
            a2_q           <= '0;
            a3_q           <= '0;
            z_q            <= 1'b0;
            bus.alu_op     <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_status <= 1'b0;
        end else begin
            if (accept) begin
                {op_q, a1_q, a2_q, a3_q} <= bus.cmd_data;
            end
            if (state_q == ISSUE) begin
                bus.alu_a  <= regs[a1_q];
                bus.alu_b  <= regs[a2_q];
                bus.alu_op <= is_cas ? OP_SUB : op_q;
            end
            if (state_q == EXEC && is_cas) begin
                z_q <= bus.alu_z;
            end
            bus.rsp_valid  <= (state_q == EXEC && !is_cas) || (state_q == SWAP);
            bus.rsp_status <= (state_q == SWAP) && z_q;
        end
    end

    // Register file write-back: ALU result in EXEC, swap plus STATUS in SWAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is cleared by reset because the
            // architecture guarantees all R[i]=0, so it cannot be mapped to
            // a reset-less RAM.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (state_q == EXEC && !is_cas) begin
                regs[a3_q] <= bus.alu_y;
            end
            if (state_q == SWAP) begin
                if (z_q) begin
                    // NOTE: non-blocking assignments make both right-hand
                    // sides read the pre-edge values, giving a true swap.
                    regs[a1_q] <= regs[a3_q];
                    regs[a3_q] <= regs[a1_q];
                end
                // Last assignment wins, so STATUS overrides a swap into it.
                regs[STATUS_IDX] <= {{(DATA_W-1){1'b0}}, z_q};
            end
        end
    end

`ifdef CAS_STATS_EN
    // Saturating CAS hit/miss statistics, updated once per CAS in SWAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cas_ok_cnt   <= '0;
            cas_fail_cnt <= '0;
        end else if (state_q == SWAP) begin
            if (z_q) begin
                if (cas_ok_cnt != 16'hFFFF) cas_ok_cnt <= cas_ok_cnt + 16'd1;
            end else begin
                if (cas_fail_cnt != 16'hFFFF) cas_fail_cnt <= cas_fail_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_atomic_alu_sequencer.sv
// tb_atomic_alu_sequencer: self-checking bench for atomic_alu_sequencer.
// The bench plays the external ALU (ADD, SUB, AND, OR, XOR, pass-B,
// load-immediate, SUB) and keeps an array model of the register file.
module tb_atomic_alu_sequencer;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int OPC_W    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [DATA_W-1:0] imm = '0;

    always #5 clk = ~clk;

    atomic_alu_sequencer_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .OPC_W(OPC_W)) bus ();

`ifdef CAS_STATS_EN
    logic [15:0] ok_cnt, fail_cnt;
`endif

    atomic_alu_sequencer #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .OPC_W(OPC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CAS_STATS_EN
        ,
        .cas_ok_cnt   (ok_cnt),
        .cas_fail_cnt (fail_cnt)
`endif
    );

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, b, im);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return b;
            3'd6:    return im;
            default: return a - b;
        endcase
    endfunction

    assign bus.alu_y = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b, imm);
    assign bus.alu_z = (bus.alu_y == '0);

    int total = 0;
    int bad   = 0;
    logic [31:0] mr [NUM_REGS];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: the ALU sees R[a1], R[a2]; CAS compares and swaps R[a1]/R[a3].
    task automatic model_cmd(input logic [2:0] op, a1, a2, a3, input logic [31:0] im,
                             output logic [31:0] ea, eb, output logic [2:0] eo,
                             output logic es, output int elat);
        logic [31:0] t;
        ea = mr[a1];
        eb = mr[a2];
        if (op == 3'd7) begin
            eo = 3'd1;
            es = (ea == eb);
            elat = 3;
            if (es) begin
                t = mr[a1];
                mr[a1] = mr[a3];
                mr[a3] = t;
            end
            mr[NUM_REGS-1] = {31'd0, es};
        end else begin
            eo = op;
            es = 1'b0;
            elat = 2;
            mr[a3] = alu_fn(op, ea, eb, im);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) mr[i] = '0;
    endtask

    // Issue one command, capture ALU drive in EXEC and the response.
    task automatic run_cmd(input logic [2:0] op, a1, a2, a3, input logic [31:0] im,
                           output logic [31:0] ga, gb, output logic [2:0] go,
                           output logic gs, output int lat);
        logic acc, leak;
        acc = 1'b0; leak = 1'b0;
        ga = '0; gb = '0; go = '0; gs = 1'b0; lat = -1;
        imm = im;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {op, a1, a2, a3};
        for (int k = 0; k < 20; k++) begin
            if (bus.cmd_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            check("accept_timeout", 32'(acc), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) begin
                ga = bus.alu_a;
                gb = bus.alu_b;
                go = bus.alu_op;
            end
            if (bus.rsp_valid) begin
                lat = k - 1;
                gs  = bus.rsp_status;
                break;
            end
            if (bus.cmd_ready) leak = 1'b1;
        end
        check("ready_low_busy", 32'(leak), 32'd0);
        @(negedge clk);
        check("rsp_pulse_width", 32'(bus.rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op, a1, a2, a3;
        logic [31:0] im, ea, eb;
        logic        es;
        int          elat;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, a1, a2, a3, input logic [31:0] im,
                                input logic [31:0] ea, eb, input logic es, input int elat);
        vec_t v;
        v.op = op; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.im = im;
        v.ea = ea; v.eb = eb; v.es = es; v.elat = elat;
        return v;
    endfunction

    task automatic read_reg(input logic [2:0] r, input logic [31:0] exp, input string name);
        logic [31:0] ga, gb, ea, eb;
        logic [2:0] go, eo;
        logic gs, es;
        int lat, elat;
        model_cmd(3'd2, r, r, r, 32'd0, ea, eb, eo, es, elat);
        run_cmd(3'd2, r, r, r, 32'd0, ga, gb, go, gs, lat);
        check(name, ga, exp);
    endtask

    vec_t tbl [27];

    initial begin
        logic [31:0] ga, gb, ea, eb;
        logic [2:0]  go, eo;
        logic        gs, es;
        int          lat, elat;
        logic [2:0]  bp_op [3], bp_a1 [3], bp_a2 [3], bp_a3 [3];
        int          accepts, rsps, busy, idx;
        int          acc_cyc [3];

        tbl[0]  = mk(3'd6, 0, 0, 1, 32'd5, 0, 0, 0, 2);
        tbl[1]  = mk(3'd6, 0, 0, 2, 32'd3, 0, 0, 0, 2);
        tbl[2]  = mk(3'd1, 1, 2, 4, 32'd0, 5, 3, 0, 2);
        tbl[3]  = mk(3'd2, 4, 4, 4, 32'd0, 2, 2, 0, 2);
        tbl[4]  = mk(3'd6, 0, 0, 1, 32'd7, 0, 0, 0, 2);
        tbl[5]  = mk(3'd6, 0, 0, 2, 32'd7, 0, 0, 0, 2);
        tbl[6]  = mk(3'd6, 0, 0, 3, 32'd9, 0, 0, 0, 2);
        tbl[7]  = mk(3'd7, 1, 2, 3, 32'd0, 7, 7, 1, 3);
        tbl[8]  = mk(3'd2, 1, 3, 5, 32'd0, 9, 7, 0, 2);
        tbl[9]  = mk(3'd2, 7, 7, 7, 32'd0, 1, 1, 0, 2);
        tbl[10] = mk(3'd6, 0, 0, 1, 32'd7, 0, 0, 0, 2);
        tbl[11] = mk(3'd6, 0, 0, 2, 32'd6, 0, 0, 0, 2);
        tbl[12] = mk(3'd6, 0, 0, 3, 32'd9, 0, 0, 0, 2);
        tbl[13] = mk(3'd7, 1, 2, 3, 32'd0, 7, 6, 0, 3);
        tbl[14] = mk(3'd3, 1, 3, 6, 32'd0, 7, 9, 0, 2);
        tbl[15] = mk(3'd2, 7, 7, 7, 32'd0, 0, 0, 0, 2);
        tbl[16] = mk(3'd6, 0, 0, 7, 32'hDEADBEEF, 0, 0, 0, 2);
        tbl[17] = mk(3'd2, 7, 7, 6, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2);
        tbl[18] = mk(3'd6, 0, 0, 1, 32'd4, 0, 0, 0, 2);
        tbl[19] = mk(3'd6, 0, 0, 2, 32'd4, 0, 0, 0, 2);
        tbl[20] = mk(3'd7, 1, 2, 1, 32'd0, 4, 4, 1, 3);
        tbl[21] = mk(3'd2, 1, 7, 6, 32'd0, 4, 1, 0, 2);
        tbl[22] = mk(3'd6, 0, 0, 7, 32'h22, 0, 0, 0, 2);
        tbl[23] = mk(3'd6, 0, 0, 1, 32'd5, 0, 0, 0, 2);
        tbl[24] = mk(3'd6, 0, 0, 2, 32'd5, 0, 0, 0, 2);
        tbl[25] = mk(3'd7, 1, 2, 7, 32'd0, 5, 5, 1, 3);
        tbl[26] = mk(3'd2, 1, 7, 5, 32'd0, 32'h22, 1, 0, 2);

        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        rst_n = 1'b1;

        // Directed table: SUB, CAS hit/miss, STATUS and a1==a3 boundaries.
        for (int i = 0; i < 27; i++) begin
            model_cmd(tbl[i].op, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].im, ea, eb, eo, es, elat);
            run_cmd(tbl[i].op, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].im, ga, gb, go, gs, lat);
            check($sformatf("v%0d_alu_a", i), ga, tbl[i].ea);
            check($sformatf("v%0d_alu_b", i), gb, tbl[i].eb);
            check($sformatf("v%0d_alu_op", i), 32'(go), (tbl[i].op == 3'd7) ? 32'd1 : 32'(tbl[i].op));
            check($sformatf("v%0d_status", i), 32'(gs), 32'(tbl[i].es));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].elat));
        end

        // Reset while a CAS hit is in SWAP: aborts with no writes.
        run_cmd(3'd6, 0, 0, 1, 32'd3, ga, gb, go, gs, lat);
        run_cmd(3'd6, 0, 0, 2, 32'd3, ga, gb, go, gs, lat);
        run_cmd(3'd6, 0, 0, 3, 32'd8, ga, gb, go, gs, lat);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {3'd7, 3'd1, 3'd2, 3'd3};
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midcas_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("midcas_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        check("midcas_rst_alu_a", bus.alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("midcas_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        for (int r = 0; r < NUM_REGS; r++) read_reg(3'(r), 32'd0, $sformatf("midcas_R%0d", r));

        // Back-pressure: cmd_valid held high across three commands.
        bp_op[0] = 3'd6; bp_a1[0] = 3'd0; bp_a2[0] = 3'd0; bp_a3[0] = 3'd5;
        bp_op[1] = 3'd0; bp_a1[1] = 3'd5; bp_a2[1] = 3'd5; bp_a3[1] = 3'd6;
        bp_op[2] = 3'd1; bp_a1[2] = 3'd6; bp_a2[2] = 3'd5; bp_a3[2] = 3'd0;
        for (int i = 0; i < 3; i++) model_cmd(bp_op[i], bp_a1[i], bp_a2[i], bp_a3[i], 32'h11, ea, eb, eo, es, elat);
        imm = 32'h11;
        accepts = 0; rsps = 0; busy = 0; idx = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {bp_op[0], bp_a1[0], bp_a2[0], bp_a3[0]};
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (bus.rsp_valid) rsps++;
            if (!bus.cmd_ready) busy++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (accepts < 3) acc_cyc[accepts] = cyc;
                accepts++;
                @(posedge clk);
                #1;
                idx++;
                if (idx < 3) bus.cmd_data = {bp_op[idx], bp_a1[idx], bp_a2[idx], bp_a3[idx]};
                else bus.cmd_valid = 1'b0;
            end
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepts", 32'(accepts), 32'd3);
        check("bp_responses", 32'(rsps), 32'd3);
        check("bp_busy_cycles", 32'(busy), 32'd6);
        check("bp_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check("bp_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        read_reg(3'd5, 32'h11, "bp_R5");
        read_reg(3'd6, 32'h22, "bp_R6");
        read_reg(3'd0, 32'h11, "bp_R0");

        // Randomized commands against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op, a1, a2, a3;
            logic [31:0] im;
            op = 3'($urandom_range(0, 7));
            a1 = 3'($urandom_range(0, 7));
            a2 = 3'($urandom_range(0, 7));
            a3 = 3'($urandom_range(0, 7));
            im = $urandom;
            if (op == 3'd7 && $urandom_range(0, 1) == 1) a2 = a1;
            model_cmd(op, a1, a2, a3, im, ea, eb, eo, es, elat);
            run_cmd(op, a1, a2, a3, im, ga, gb, go, gs, lat);
            check($sformatf("rnd%0d_alu_a", i), ga, ea);
            check($sformatf("rnd%0d_alu_b", i), gb, eb);
            check($sformatf("rnd%0d_alu_op", i), 32'(go), 32'(eo));
            check($sformatf("rnd%0d_status", i), 32'(gs), 32'(es));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
        end
        for (int r = 0; r < NUM_REGS; r++) read_reg(3'(r), mr[r], $sformatf("rnd_final_R%0d", r));

`ifdef CAS_STATS_EN
        // CAS statistics: 2 hits, 1 miss, then saturation.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("stats_rst_ok", 32'(ok_cnt), 32'd0);
        check("stats_rst_fail", 32'(fail_cnt), 32'd0);
        run_cmd(3'd6, 0, 0, 1, 32'd1, ga, gb, go, gs, lat);
        run_cmd(3'd6, 0, 0, 2, 32'd1, ga, gb, go, gs, lat);
        run_cmd(3'd7, 1, 2, 1, 32'd0, ga, gb, go, gs, lat);
        run_cmd(3'd7, 1, 2, 1, 32'd0, ga, gb, go, gs, lat);
        run_cmd(3'd6, 0, 0, 2, 32'd2, ga, gb, go, gs, lat);
        run_cmd(3'd7, 1, 2, 1, 32'd0, ga, gb, go, gs, lat);
        check("stats_ok", 32'(ok_cnt), 32'd2);
        check("stats_fail", 32'(fail_cnt), 32'd1);
        @(negedge clk);
        force dut.cas_ok_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.cas_ok_cnt;
        run_cmd(3'd7, 1, 1, 1, 32'd0, ga, gb, go, gs, lat);
        check("stats_ok_sat", 32'(ok_cnt), 32'h0000FFFF);
        check("stats_fail_hold", 32'(fail_cnt), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
